// File: rtl/ads131_pkg.sv
// ads131_pkg: opcodes, response words and state encodings shared by the ADS131A0x responder
package ads131_pkg;
    localparam int WORD_BITS = 16;
    localparam logic [15:0] CMD_NULL    = 16'h0000;
    localparam logic [15:0] CMD_RESET   = 16'h0011;
    localparam logic [15:0] CMD_STANDBY = 16'h0022;
    localparam logic [15:0] CMD_WAKEUP  = 16'h0033;
    localparam logic [15:0] CMD_LOCK    = 16'h0555;
    localparam logic [15:0] CMD_UNLOCK  = 16'h0655;
    localparam logic [2:0]  PFX_RREG    = 3'b001;
    localparam logic [2:0]  PFX_WREG    = 3'b010;
    localparam logic [15:0] RESP_POR    = 16'hFF04;
    localparam logic [15:0] RESP_READY  = 16'h2200;
    typedef enum logic [1:0] {DEV_POR, DEV_LOCKED, DEV_UNLOCKED} dev_state_t;
    typedef enum logic {SH_IDLE, SH_ACTIVE} shift_state_t;
endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync: two-flop synchroniser with rise/fall detect for one asynchronous pin
module spi_input_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic system_clock,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1, r_s2, r_s3;
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) {r_s1, r_s2, r_s3} <= {3{RST_VAL}};
        else          {r_s1, r_s2, r_s3} <= {i_d, r_s1, r_s2};
    end
    assign o_q    = r_s2;
    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;
endmodule

// File: rtl/ads131_spi_responder.sv
// ads131_spi_responder: oversampled SPI slave emulating an ADS131A0x ADC for bench bring-up
module ads131_spi_responder
    import ads131_pkg::*;
#(
    parameter int          NUM_CH = 4,
    parameter logic [7:0]  REG_ID = 8'h04
) (
    input  logic                   system_clock,
    input  logic                   reset_n,
    input  logic                   SPI_SCLK,
    input  logic                   SPI_CS,
    input  logic                   SPI_MOSI,
    output logic                   SPI_MISO,
    input  logic                   SPI_RESET,
    input  logic [NUM_CH*16-1:0]   sample_data,
    input  logic                   sample_valid,
    output logic                   drdy_n,
    output logic                   frame_done,
    output logic [15:0]            last_cmd,
    output logic                   adc_enabled,
    output logic                   dev_unlocked
);
    localparam int SW = (1 + NUM_CH) * WORD_BITS;
    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_cs_q, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_rst_q, w_rst_rise, w_rst_fall;
    logic w_unused;
    spi_input_sync #(.RST_VAL(1'b0)) u_sclk (.system_clock, .reset_n, .i_d(SPI_SCLK),  .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    spi_input_sync #(.RST_VAL(1'b1)) u_cs   (.system_clock, .reset_n, .i_d(SPI_CS),    .o_q(w_cs_q),   .o_rise(w_cs_rise),   .o_fall(w_cs_fall));
    spi_input_sync #(.RST_VAL(1'b0)) u_mosi (.system_clock, .reset_n, .i_d(SPI_MOSI),  .o_q(w_mosi),   .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));
    spi_input_sync #(.RST_VAL(1'b1)) u_rst  (.system_clock, .reset_n, .i_d(SPI_RESET), .o_q(w_rst_q),  .o_rise(w_rst_rise),  .o_fall(w_rst_fall));
    assign w_unused = ^{w_sclk_q, w_cs_q, w_mosi_rise, w_mosi_fall, w_rst_rise, w_rst_fall};

    shift_state_t      r_shift_st;
    dev_state_t        r_dev;
    logic [SW-1:0]     r_shift;
    logic              r_miso;
    logic [15:0]       r_rx;
    logic [4:0]        r_rx_cnt;
    logic              r_frame_done;
    logic [15:0]       r_resp;
    logic [15:0]       r_last_cmd;
    logic              r_adc_en;
    logic [7:0]        r_regs [32];
    logic [NUM_CH*16-1:0] r_hold;
    logic              r_drdy_n;
    logic              w_dev_rst, w_frame_start, w_cmd_ok;
    logic [NUM_CH*16-1:0] w_chans;
    dev_state_t        w_nxt_dev;
    logic [15:0]       w_nxt_resp;
    logic              w_nxt_en, w_reg_rst, w_wr;
    logic [4:0]        w_addr;

    assign w_dev_rst     = ~w_rst_q;
    assign w_frame_start = w_cs_fall && r_shift_st == SH_IDLE && !w_dev_rst;
    assign w_cmd_ok      = w_cs_rise && r_shift_st == SH_ACTIVE && !w_dev_rst && r_rx_cnt == 5'(WORD_BITS);
    assign w_addr        = r_rx[12:8];

    // Frame order is ch0 first on the wire, but ch0 sits in the LSBs of the holding register
    always_comb begin
        w_chans = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_chans[(NUM_CH-1-i)*16 +: 16] = r_adc_en ? r_hold[i*16 +: 16] : 16'h0000;
    end

    always_comb begin
        w_nxt_dev  = r_dev;
        w_nxt_resp = (r_dev == DEV_POR) ? RESP_POR : RESP_READY;
        w_nxt_en   = r_adc_en;
        w_reg_rst  = 1'b0;
        w_wr       = 1'b0;
        if (r_rx == CMD_RESET) begin
            w_nxt_dev  = DEV_POR;
            w_nxt_resp = RESP_POR;
            w_nxt_en   = 1'b0;
            w_reg_rst  = 1'b1;
        end else if (r_rx == CMD_UNLOCK && r_dev != DEV_UNLOCKED) begin
            w_nxt_dev  = DEV_UNLOCKED;
            w_nxt_resp = CMD_UNLOCK;
        end else if (r_rx == CMD_LOCK && r_dev == DEV_UNLOCKED) begin
            w_nxt_dev  = DEV_LOCKED;
            w_nxt_resp = CMD_LOCK;
        end else if ((r_rx == CMD_WAKEUP || r_rx == CMD_STANDBY) && r_dev == DEV_UNLOCKED) begin
            w_nxt_en   = r_rx == CMD_WAKEUP;
            w_nxt_resp = r_rx;
        end else if (r_rx[15:13] == PFX_RREG && r_dev != DEV_POR) begin
            w_nxt_resp = {PFX_RREG, w_addr, r_regs[w_addr]};
        end else if (r_rx[15:13] == PFX_WREG && r_dev == DEV_UNLOCKED) begin
            w_wr       = 1'b1;
            w_nxt_resp = {PFX_RREG, r_rx[12:0]};
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift_st   <= SH_IDLE;
            r_shift      <= '0;
            r_miso       <= 1'b0;
            r_rx         <= '0;
            r_rx_cnt     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_dev_rst) begin
                r_shift_st <= SH_IDLE;
                r_miso     <= 1'b0;
            end else if (r_shift_st == SH_IDLE) begin
                r_miso <= 1'b0;
                if (w_cs_fall) begin
                    r_shift_st <= SH_ACTIVE;
                    r_shift    <= {r_resp, w_chans};
                    r_rx_cnt   <= '0;
                end
            end else if (w_cs_rise) begin
                r_shift_st   <= SH_IDLE;
                r_miso       <= 1'b0;
                r_frame_done <= 1'b1;
            end else begin
                if (w_sclk_rise) begin
                    r_miso  <= r_shift[SW-1];
                    r_shift <= r_shift << 1;
                end
                if (w_sclk_fall && r_rx_cnt != 5'(WORD_BITS)) begin
                    r_rx     <= {r_rx[14:0], w_mosi};
                    r_rx_cnt <= r_rx_cnt + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dev      <= DEV_POR;
            r_resp     <= RESP_POR;
            r_adc_en   <= 1'b0;
            r_last_cmd <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= (i == 0) ? REG_ID : 8'h00;
        end else if (w_dev_rst) begin
            r_dev    <= DEV_POR;
            r_resp   <= RESP_POR;
            r_adc_en <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= (i == 0) ? REG_ID : 8'h00;
        end else if (w_cmd_ok) begin
            r_last_cmd <= r_rx;
            r_dev      <= w_nxt_dev;
            r_resp     <= w_nxt_resp;
            r_adc_en   <= w_nxt_en;
            if (w_reg_rst)
                for (int i = 0; i < 32; i++) r_regs[i] <= (i == 0) ? REG_ID : 8'h00;
            else if (w_wr)
                r_regs[w_addr] <= r_rx[7:0];
        end
    end

    // A sample arriving on the same cycle as a frame start wins over the frame's drdy clear
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold   <= '0;
            r_drdy_n <= 1'b1;
        end else begin
            if (sample_valid) r_hold <= sample_data;
            r_drdy_n <= sample_valid ? 1'b0 : (w_frame_start ? 1'b1 : r_drdy_n);
        end
    end

    assign SPI_MISO     = r_miso;
    assign drdy_n       = r_drdy_n;
    assign frame_done   = r_frame_done;
    assign last_cmd     = r_last_cmd;
    assign adc_enabled  = r_adc_en;
    assign dev_unlocked = r_dev == DEV_UNLOCKED;
endmodule

// File: tb/tb_ads131_spi_responder.sv
// tb_ads131_spi_responder: table-driven and randomized checks of the ADS131A0x responder
module tb_ads131_spi_responder;
    localparam int NUM_CH = 4;
    localparam int SW = (1 + NUM_CH) * 16;
    localparam int RW = SW + 8;

    logic clk = 1'b0, reset_n = 1'b0;
    logic sclk = 1'b0, cs = 1'b1, mosi = 1'b0, spi_reset = 1'b1, sample_valid = 1'b0;
    logic [NUM_CH*16-1:0] sample_data = '0;
    logic miso, drdy_n, frame_done, adc_enabled, dev_unlocked;
    logic [15:0] last_cmd;

    ads131_spi_responder #(.NUM_CH(NUM_CH), .REG_ID(8'h04)) dut (
        .system_clock(clk), .reset_n(reset_n), .SPI_SCLK(sclk), .SPI_CS(cs),
        .SPI_MOSI(mosi), .SPI_MISO(miso), .SPI_RESET(spi_reset),
        .sample_data(sample_data), .sample_valid(sample_valid), .drdy_n(drdy_n),
        .frame_done(frame_done), .last_cmd(last_cmd), .adc_enabled(adc_enabled),
        .dev_unlocked(dev_unlocked));

    always #10 clk = ~clk;

    int checks = 0, errors = 0, fd_cnt = 0;
    always @(negedge clk) if (frame_done) fd_cnt++;

    // Reference model of the device as the command rules describe it
    int m_dev;
    logic [7:0] m_regs [32];
    logic m_en;
    logic [15:0] m_resp, m_last;
    logic [NUM_CH*16-1:0] m_hold;

    function automatic void m_reset();
        m_dev = 0; m_resp = 16'hFF04; m_en = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = (i == 0) ? 8'h04 : 8'h00;
    endfunction

    function automatic void m_apply(input logic [15:0] c);
        m_last = c;
        m_resp = (m_dev == 0) ? 16'hFF04 : 16'h2200;
        if (c == 16'h0011) m_reset();
        else if (c == 16'h0655 && m_dev != 2) begin m_dev = 2; m_resp = c; end
        else if (c == 16'h0555 && m_dev == 2) begin m_dev = 1; m_resp = c; end
        else if ((c == 16'h0033 || c == 16'h0022) && m_dev == 2) begin m_en = (c == 16'h0033); m_resp = c; end
        else if (c[15:13] == 3'b001 && m_dev != 0) m_resp = {3'b001, c[12:8], m_regs[c[12:8]]};
        else if (c[15:13] == 3'b010 && m_dev == 2) begin m_regs[c[12:8]] = c[7:0]; m_resp = {3'b001, c[12:0]}; end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clock_bits(input logic [15:0] cmd, input int nbits, output logic [RW-1:0] rx);
        rx = '0;
        for (int b = 0; b < nbits; b++) begin
            sclk = 1'b1;
            mosi = (b < 16) ? cmd[15-b] : 1'($urandom_range(0, 1));
            wait_clks(6);
            if (b < RW) rx[RW-1-b] = miso;
            sclk = 1'b0;
            wait_clks(6);
        end
    endtask

    task automatic spi_frame(input logic [15:0] cmd, input int nbits, input bit sv_at_fall,
                             input logic [NUM_CH*16-1:0] sv_data, output logic [RW-1:0] rx, output logic d3);
        cs = 1'b0;
        if (sv_at_fall) begin
            wait_clks(2);
            sample_data = sv_data; sample_valid = 1'b1;
            wait_clks(1);
            sample_valid = 1'b0;
        end else wait_clks(3);
        d3 = drdy_n;
        wait_clks(5);
        clock_bits(cmd, nbits, rx);
        wait_clks(4);
        cs = 1'b1;
        wait_clks(8);
    endtask

    task automatic sample(input logic [NUM_CH*16-1:0] d);
        sample_data = d; sample_valid = 1'b1;
        wait_clks(1);
        sample_valid = 1'b0;
        m_hold = d;
        wait_clks(1);
    endtask

    task automatic frame_model(input string tag, input logic [15:0] cmd, input int nbits);
        logic [RW-1:0] rx;
        logic d3;
        logic [15:0] ew0;
        logic [NUM_CH*16-1:0] ech;
        int fd0;
        ew0 = m_resp;
        ech = m_en ? m_hold : '0;
        fd0 = fd_cnt;
        spi_frame(cmd, nbits, 1'b0, '0, rx, d3);
        if (nbits >= SW) begin
            chk({tag, " word0"}, 32'(rx[RW-1 -: 16]), 32'(ew0));
            for (int k = 0; k < NUM_CH; k++)
                chk($sformatf("%s ch%0d", tag, k), 32'(rx[RW-1-16*(k+1) -: 16]), 32'(ech[k*16 +: 16]));
        end
        if (nbits == RW) chk({tag, " tail zeros"}, 32'(rx[7:0]), 32'h0);
        chk({tag, " drdy after cs fall"}, 32'(d3), 32'h1);
        if (nbits >= 16) m_apply(cmd);
        chk({tag, " frame_done count"}, 32'(fd_cnt - fd0), 32'h1);
        chk({tag, " unlocked"}, 32'(dev_unlocked), 32'(m_dev == 2));
        chk({tag, " adc_enabled"}, 32'(adc_enabled), 32'(m_en));
        chk({tag, " last_cmd"}, 32'(last_cmd), 32'(m_last));
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] word0;
        logic        unl;
        logic        en;
    } vec_t;
    vec_t vt [14];

    logic [RW-1:0] rx;
    logic d3;
    logic [15:0] c;
    logic [NUM_CH*16-1:0] plan_d, d2;
    int fd0, r, nb;

    initial begin
        vt[0]  = '{16'h0000, 16'hFF04, 1'b0, 1'b0};
        vt[1]  = '{16'h0655, 16'hFF04, 1'b1, 1'b0};
        vt[2]  = '{16'h0000, 16'h0655, 1'b1, 1'b0};
        vt[3]  = '{16'h0000, 16'h2200, 1'b1, 1'b0};
        vt[4]  = '{16'h4112, 16'h2200, 1'b1, 1'b0};
        vt[5]  = '{16'h2100, 16'h2112, 1'b1, 1'b0};
        vt[6]  = '{16'h0000, 16'h2112, 1'b1, 1'b0};
        vt[7]  = '{16'h0555, 16'h2200, 1'b0, 1'b0};
        vt[8]  = '{16'h4155, 16'h0555, 1'b0, 1'b0};
        vt[9]  = '{16'h2100, 16'h2200, 1'b0, 1'b0};
        vt[10] = '{16'h0000, 16'h2112, 1'b0, 1'b0};
        vt[11] = '{16'h0655, 16'h2200, 1'b1, 1'b0};
        vt[12] = '{16'h0033, 16'h0655, 1'b1, 1'b1};
        vt[13] = '{16'h0000, 16'h0033, 1'b1, 1'b1};
        plan_d = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
        d2     = {16'h0D0C, 16'h0B0A, 16'h0908, 16'h0706};
        m_reset(); m_last = '0; m_hold = '0;

        wait_clks(4);
        chk("reset miso", 32'(miso), 32'h0);
        chk("reset drdy_n", 32'(drdy_n), 32'h1);
        chk("reset frame_done", 32'(frame_done), 32'h0);
        chk("reset last_cmd", 32'(last_cmd), 32'h0);
        chk("reset adc_enabled", 32'(adc_enabled), 32'h0);
        chk("reset unlocked", 32'(dev_unlocked), 32'h0);
        reset_n = 1'b1;
        wait_clks(4);

        for (int i = 0; i < 14; i++) begin
            fd0 = fd_cnt;
            spi_frame(vt[i].cmd, SW, 1'b0, '0, rx, d3);
            chk($sformatf("vec%0d word0", i), 32'(rx[RW-1 -: 16]), 32'(vt[i].word0));
            for (int k = 0; k < NUM_CH; k++)
                chk($sformatf("vec%0d ch%0d", i, k), 32'(rx[RW-1-16*(k+1) -: 16]), 32'h0);
            chk($sformatf("vec%0d frame_done", i), 32'(fd_cnt - fd0), 32'h1);
            chk($sformatf("vec%0d unlocked", i), 32'(dev_unlocked), 32'(vt[i].unl));
            chk($sformatf("vec%0d adc_enabled", i), 32'(adc_enabled), 32'(vt[i].en));
            chk($sformatf("vec%0d last_cmd", i), 32'(last_cmd), 32'(vt[i].cmd));
            m_apply(vt[i].cmd);
        end

        sample(plan_d);
        chk("drdy after sample", 32'(drdy_n), 32'h0);
        frame_model("sampled frame", 16'h0000, RW);
        chk("ch0 plan value", 32'(m_hold[15:0]), 32'h1234);

        sample(plan_d);
        spi_frame(16'h0000, SW, 1'b1, d2, rx, d3);
        m_apply(16'h0000); m_hold = d2;
        chk("coincident drdy stays low", 32'(d3), 32'h0);
        chk("coincident ch0 old data", 32'(rx[RW-17 -: 16]), 32'h1234);
        chk("coincident ch3 old data", 32'(rx[RW-65 -: 16]), 32'hDEF0);
        frame_model("after coincident", 16'h0000, SW);

        frame_model("short unlock", 16'h0655, 9);
        chk("short last_cmd kept", 32'(last_cmd), 32'h0000);
        frame_model("after short", 16'h0000, SW);

        spi_reset = 1'b0; wait_clks(5);
        spi_reset = 1'b1; wait_clks(5);
        m_reset();
        chk("pin reset unlocked", 32'(dev_unlocked), 32'h0);
        chk("pin reset adc_enabled", 32'(adc_enabled), 32'h0);
        frame_model("after pin reset", 16'h0655, SW);
        chk("pin reset word0 const", 32'(m_last), 32'h0655);

        fd0 = fd_cnt;
        cs = 1'b0; wait_clks(8);
        clock_bits(16'h0033, 20, rx);
        sclk = 1'b1; wait_clks(4);
        spi_reset = 1'b0; wait_clks(5);
        chk("pin reset mid-frame miso", 32'(miso), 32'h0);
        sclk = 1'b0; spi_reset = 1'b1; wait_clks(6);
        cs = 1'b1; wait_clks(8);
        m_reset();
        chk("pin reset frame_done suppressed", 32'(fd_cnt - fd0), 32'h0);
        frame_model("fresh frame", 16'h0655, SW);

        cs = 1'b0; wait_clks(8);
        clock_bits(16'h0033, 20, rx);
        reset_n = 1'b0; #1;
        chk("async reset drdy_n", 32'(drdy_n), 32'h1);
        chk("async reset last_cmd", 32'(last_cmd), 32'h0);
        chk("async reset unlocked", 32'(dev_unlocked), 32'h0);
        chk("async reset miso", 32'(miso), 32'h0);
        cs = 1'b1; wait_clks(4);
        reset_n = 1'b1; wait_clks(4);
        m_reset(); m_last = '0; m_hold = '0;

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 8))
                0: c = 16'h0000;
                1: c = 16'h0655;
                2: c = 16'h0555;
                3: c = 16'h0033;
                4: c = 16'h0022;
                5: c = 16'h0011;
                6: c = {3'b001, 5'($urandom_range(0, 3)), 8'($urandom)};
                7: c = {3'b010, 5'($urandom_range(0, 3)), 8'($urandom)};
                default: c = 16'($urandom);
            endcase
            r = $urandom_range(0, 9);
            nb = (r == 0) ? 9 : ((r < 4) ? RW : SW);
            if ($urandom_range(0, 2) == 0) sample({$urandom, $urandom});
            frame_model($sformatf("rand%0d", i), c, nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
